// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types and default sizes for the flash transaction initiator.
//   flash_cmd_t  : one queued core command (write flag + write data)
//   fti_state_t  : initiator FSM states
//   ptrWidth()   : pointer width for a power-of-two queue depth
package ssd_pkg;

  localparam int FLASH_DATA_W     = 32;
  localparam int FLASH_FIFO_DEPTH = 4;
  localparam int FLASH_TIMEOUT    = 256;
  localparam int FLASH_MAX_RETRY  = 2;

  typedef struct packed {
    logic                    write;
    logic [FLASH_DATA_W-1:0] wdata;
  } flash_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } fti_state_t;

  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/flash_req_fifo.sv
// flash_req_fifo: synchronous request queue of flash_cmd_t entries.
//   clk, rst     : clock, asynchronous active-high reset (flushes the queue)
//   push_i       : write pushData_i when not full
//   pop_i        : advance the head when not empty; popData_o shows the head
//   full_o       : DEPTH entries held (a same-cycle pop does not free a slot)
//   empty_o      : no entries held (no bypass: a push is visible next cycle)
//   count_o      : number of entries held
module flash_req_fifo
  import ssd_pkg::*;
#(
  parameter  int DEPTH = FLASH_FIFO_DEPTH,
  localparam int PTR_W = ptrWidth(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  flash_cmd_t       pushData_i,
  input  logic             pop_i,
  output flash_cmd_t       popData_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  flash_cmd_t       mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign doPush    = push_i & ~full_o;
  assign doPop     = pop_i & ~empty_o;
  assign popData_o = mem[rdPtr_q];
  assign count_o   = count_q;

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr_q] <= pushData_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/flash_txn_initiator.sv
// flash_txn_initiator: queues core commands and runs them one at a time over the
// flash read/write/ready strobe interface, returning one response per command in order.
//   clk, rst                         : clock, asynchronous active-high reset
//   req_valid_i/req_ready_o          : command handshake (req_ready_o = queue not full)
//   req_write_i, req_wdata_i         : command kind and write data
//   rsp_valid_o/rsp_ready_i          : response handshake, response held until accepted
//   rsp_rdata_o, rsp_err_o           : read data (0 for writes/errors), abort flag
//   flash_read_o, flash_write_o      : strobes to the flash responder (never both high)
//   flash_wdata_o, flash_rdata_i     : flash write data out, read data in
//   flash_ready_i                    : responder completion
//   busy_o                           : queue non-empty or a command in progress
// Build option: define FLASH_TIMEOUT_EN to abort and re-issue a strobe after
// TIMEOUT_CYCLES without flash_ready, giving up with rsp_err after MAX_RETRY re-issues.
// DATA_W must match ssd_pkg::FLASH_DATA_W, the width carried by the queue entries.
module flash_txn_initiator
  import ssd_pkg::*;
#(
  parameter int DATA_W         = FLASH_DATA_W,
  parameter int FIFO_DEPTH     = FLASH_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = FLASH_TIMEOUT,
  parameter int MAX_RETRY      = FLASH_MAX_RETRY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              flash_read_o,
  output logic              flash_write_o,
  output logic [DATA_W-1:0] flash_wdata_o,
  input  logic [DATA_W-1:0] flash_rdata_i,
  input  logic              flash_ready_i,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  flash_cmd_t        pushCmd;
  flash_cmd_t        headCmd;
  flash_cmd_t        issueCmd;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  logic              pop;
  logic              reissuePending;
  logic              reissueGo;
  logic              startIssue;

  fti_state_t        state_q;
  logic              flashRead_q;
  logic              flashWrite_q;
  logic [DATA_W-1:0] flashWdata_q;
  logic              rspValid_q;
  logic [DATA_W-1:0] rspRdata_q;

`ifdef FLASH_TIMEOUT_EN
  localparam int WAIT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  flash_cmd_t        cmd_q;
  logic [WAIT_W-1:0] waitCnt_q;
  logic [RETRY_W-1:0] retry_q;
  logic              reissue_q;
  logic              rspErr_q;

  // A timed-out command goes back through IDLE so the same ready gating applies
  // before its strobe is raised again.
  assign reissuePending = reissue_q;
  assign reissueGo      = (state_q == IDLE) && reissue_q && !flash_ready_i;
  assign issueCmd       = reissue_q ? cmd_q : headCmd;
  assign rsp_err_o      = rspErr_q;
`else
  logic unusedTimeoutCfg;

  assign unusedTimeoutCfg = ^{TIMEOUT_CYCLES, MAX_RETRY};
  assign reissuePending   = 1'b0;
  assign reissueGo        = 1'b0;
  assign issueCmd         = headCmd;
  assign rsp_err_o        = 1'b0;
`endif

  assign pushCmd = {req_write_i, req_wdata_i};

  // flash_ready still high in IDLE belongs to the transfer just closed, so hold off.
  assign pop        = (state_q == IDLE) && !fifoEmpty && !flash_ready_i && !reissuePending;
  assign startIssue = pop || reissueGo;

  assign req_ready_o   = ~fifoFull;
  assign busy_o        = (fifoCount != '0) || (state_q != IDLE) || reissuePending;
  assign rsp_valid_o   = rspValid_q;
  assign rsp_rdata_o   = rspRdata_q;
  assign flash_read_o  = flashRead_q;
  assign flash_write_o = flashWrite_q;
  assign flash_wdata_o = flashWdata_q;

  flash_req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) uReqFifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (req_valid_i),
    .pushData_i(pushCmd),
    .pop_i     (pop),
    .popData_o (headCmd),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty),
    .count_o   (fifoCount)
  );

  // Strobes are loaded on the IDLE->ISSUE edge so they are already high in ISSUE,
  // giving strobe at accept+2 and response at accept+4 with a one-cycle responder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      flashRead_q  <= 1'b0;
      flashWrite_q <= 1'b0;
      flashWdata_q <= '0;
      rspValid_q   <= 1'b0;
      rspRdata_q   <= '0;
`ifdef FLASH_TIMEOUT_EN
      cmd_q        <= '0;
      waitCnt_q    <= '0;
      retry_q      <= '0;
      reissue_q    <= 1'b0;
      rspErr_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (startIssue) begin
            state_q      <= ISSUE;
            flashRead_q  <= ~issueCmd.write;
            flashWrite_q <= issueCmd.write;
            flashWdata_q <= issueCmd.write ? issueCmd.wdata : '0;
`ifdef FLASH_TIMEOUT_EN
            cmd_q        <= issueCmd;
            reissue_q    <= 1'b0;
            if (pop) begin
              retry_q <= '0;
            end
`endif
          end
        end
        ISSUE: begin
          state_q <= WAIT;
`ifdef FLASH_TIMEOUT_EN
          // The ISSUE cycle counts toward the strobe's time budget.
          waitCnt_q <= WAIT_W'(1);
`endif
        end
        WAIT: begin
          if (flash_ready_i) begin
            state_q      <= RESP;
            flashRead_q  <= 1'b0;
            flashWrite_q <= 1'b0;
            flashWdata_q <= '0;
            rspValid_q   <= 1'b1;
            rspRdata_q   <= flashRead_q ? flash_rdata_i : '0;
`ifdef FLASH_TIMEOUT_EN
            rspErr_q     <= 1'b0;
`endif
          end
`ifdef FLASH_TIMEOUT_EN
          else if (waitCnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            flashRead_q  <= 1'b0;
            flashWrite_q <= 1'b0;
            flashWdata_q <= '0;
            if (retry_q == RETRY_W'(MAX_RETRY)) begin
              state_q    <= RESP;
              rspValid_q <= 1'b1;
              rspRdata_q <= '0;
              rspErr_q   <= 1'b1;
            end else begin
              state_q   <= IDLE;
              retry_q   <= retry_q + 1'b1;
              reissue_q <= 1'b1;
            end
          end else begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q    <= IDLE;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
`ifdef FLASH_TIMEOUT_EN
            rspErr_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_txn_initiator.sv
// tb_flash_txn_initiator: self-checking bench for flash_txn_initiator.
// A clocked responder model answers strobes after a programmable delay; a
// transaction-level model (queue of accepted commands) predicts every response
// and the strobe kind/data seen while a command is in flight.
// Optional timeout test runs when FLASH_TIMEOUT_EN is defined.
module tb_flash_txn_initiator;

  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int TMO     = 8;
  localparam int RETRIES = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic          reqWrite = 1'b0;
  logic [DW-1:0] reqWdata = '0;
  logic          rspValid;
  logic          rspReady = 1'b0;
  logic [DW-1:0] rspRdata;
  logic          rspErr;
  logic          flashRead;
  logic          flashWrite;
  logic [DW-1:0] flashWdata;
  logic [DW-1:0] flashRdata;
  logic          flashReady;
  logic          busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  flash_txn_initiator #(
    .DATA_W        (DW),
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY     (RETRIES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (reqValid),
    .req_ready_o  (reqReady),
    .req_write_i  (reqWrite),
    .req_wdata_i  (reqWdata),
    .rsp_valid_o  (rspValid),
    .rsp_ready_i  (rspReady),
    .rsp_rdata_o  (rspRdata),
    .rsp_err_o    (rspErr),
    .flash_read_o (flashRead),
    .flash_write_o(flashWrite),
    .flash_wdata_o(flashWdata),
    .flash_rdata_i(flashRdata),
    .flash_ready_i(flashReady),
    .busy_o       (busy)
  );

  // Read data the responder returns for its n-th completion since reset.
  function automatic logic [31:0] rdataFor(input int n);
    return 32'hDEADBEEF + 32'(n) * 32'h01000193;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Responder: raises ready respLat cycles after seeing a strobe, for one cycle.
  int respLat = 0;
  bit stall = 1'b0;
  int complCount;
  int strobeAge;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      flashReady <= 1'b0;
      flashRdata <= '0;
      strobeAge  <= 0;
      complCount <= 0;
    end else if ((flashRead || flashWrite) && !flashReady) begin
      if (!stall && strobeAge >= respLat) begin
        flashReady <= 1'b1;
        flashRdata <= rdataFor(complCount);
        complCount <= complCount + 1;
      end
      strobeAge <= strobeAge + 1;
    end else begin
      flashReady <= 1'b0;
      strobeAge  <= 0;
    end
  end

  // Transaction model: every accepted command is owed exactly one response, in order.
  typedef struct {
    bit          write;
    logic [31:0] wdata;
    bit          err;
  } txn_t;

  txn_t pendQ[$];
  int   modelCompl = 0;
  bit   modelExpectErr = 1'b0;
  int   rspCount = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (reqValid && reqReady) begin
        txn_t t;
        t.write = reqWrite;
        t.wdata = reqWdata;
        t.err   = modelExpectErr;
        pendQ.push_back(t);
      end
      if (flashRead || flashWrite) begin
        checkOutput("strobe_has_cmd", 32'(pendQ.size() != 0), 32'd1);
        if (pendQ.size() != 0) begin
          checkOutput("strobe_kind", {30'd0, flashRead, flashWrite},
                      pendQ[0].write ? 32'd1 : 32'd2);
          if (pendQ[0].write) begin
            checkOutput("flash_wdata", flashWdata, pendQ[0].wdata);
          end
        end
      end
      if (rspValid && rspReady) begin
        rspCount++;
        checkOutput("rsp_expected", 32'(pendQ.size() != 0), 32'd1);
        if (pendQ.size() != 0) begin
          txn_t t;
          t = pendQ.pop_front();
          checkOutput("rsp_rdata", rspRdata,
                      (t.write || t.err) ? 32'd0 : rdataFor(modelCompl));
          checkOutput("rsp_err", {31'd0, rspErr}, {31'd0, t.err});
          if (!t.err) modelCompl++;
        end
      end
    end
  end

  task automatic applyReset();
    reqValid = 1'b0;
    rspReady = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    pendQ.delete();
    modelCompl = 0;
    #1 rst = 1'b0;
  endtask

  // Present one command and hold it until accepted (bounded).
  task automatic applyStimulus(input bit write, input logic [31:0] wdata);
    bit accepted;
    accepted = 1'b0;
    reqValid = 1'b1;
    reqWrite = write;
    reqWdata = wdata;
    for (int i = 0; i < 60 && !accepted; i++) begin
      accepted = reqReady;
      tick();
    end
    reqValid = 1'b0;
    checkOutput("req_accepted", {31'd0, accepted}, 32'd1);
  endtask

  task automatic waitIdle(input string name);
    for (int i = 0; i < 400 && (busy || rspValid || pendQ.size() != 0); i++) tick();
    checkOutput(name, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    bit          write;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] expRdata;
    int          expRspCycle;
    int          expStrobeCycles;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int cyc;
    int strobes;
    int seen;
    int held;
    int startCount;
    int accepted;
    bit acc;

    // Single-command vectors; read data indices follow completion order since reset.
    vecs[0] = '{1'b0, 32'h0000_0000, 0, 32'hDEADBEEF, 4, 2};
    vecs[1] = '{1'b1, 32'h1234_5678, 0, 32'h0000_0000, 4, 2};
    vecs[2] = '{1'b0, 32'h0000_0000, 2, rdataFor(2),  6, 4};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 1, 32'h0000_0000, 5, 3};
    vecs[4] = '{1'b0, 32'h0000_0000, 3, rdataFor(4),  7, 5};
    vecs[5] = '{1'b1, 32'h0000_0000, 0, 32'h0000_0000, 4, 2};

    #1;
    applyReset();
    #1;
    checkOutput("reset_req_ready", {31'd0, reqReady}, 32'd1);
    checkOutput("reset_rsp_valid", {31'd0, rspValid}, 32'd0);
    checkOutput("reset_rsp_err", {31'd0, rspErr}, 32'd0);
    checkOutput("reset_rsp_rdata", rspRdata, 32'd0);
    checkOutput("reset_strobes", {30'd0, flashRead, flashWrite}, 32'd0);
    checkOutput("reset_flash_wdata", flashWdata, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    tick();

    $display("[TB] table-driven single commands");
    foreach (vecs[i]) begin
      respLat  = vecs[i].lat;
      rspReady = 1'b1;
      reqValid = 1'b1;
      reqWrite = vecs[i].write;
      reqWdata = vecs[i].wdata;
      tick();
      reqValid = 1'b0;
      cyc = 1;
      strobes = 0;
      while (!rspValid && cyc < 40) begin
        tick();
        cyc++;
        if (flashRead || flashWrite) strobes++;
      end
      checkOutput("vec_rsp_cycle", 32'(cyc), 32'(vecs[i].expRspCycle));
      checkOutput("vec_strobe_cycles", 32'(strobes), 32'(vecs[i].expStrobeCycles));
      checkOutput("vec_rsp_rdata", rspRdata, vecs[i].expRdata);
      checkOutput("vec_rsp_err", {31'd0, rspErr}, 32'd0);
      waitIdle("vec_idle");
      tick();
    end

    $display("[TB] backpressure with stalled flash");
    stall    = 1'b1;
    respLat  = 0;
    rspReady = 1'b1;
    startCount = rspCount;
    accepted = 0;
    reqValid = 1'b1;
    for (int i = 0; i < 20 && accepted < 5; i++) begin
      reqWrite = accepted[0];
      reqWdata = 32'hB000_0000 + 32'(accepted);
      acc = reqReady;
      tick();
      if (acc) accepted++;
    end
    checkOutput("bp_accepted", 32'(accepted), 32'd5);
    checkOutput("bp_req_ready_full", {31'd0, reqReady}, 32'd0);
    reqWrite = 1'b1;
    reqWdata = 32'hB000_00FF;
    tick();
    checkOutput("bp_still_full", {31'd0, reqReady}, 32'd0);
    reqValid = 1'b0;
    stall = 1'b0;
    waitIdle("bp_idle");
    checkOutput("bp_rsp_count", 32'(rspCount - startCount), 32'd5);

    $display("[TB] response stall");
    rspReady = 1'b0;
    respLat  = 0;
    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0);
    for (int i = 0; i < 40 && !rspValid; i++) tick();
    held = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rspValid && rspRdata === rdataFor(modelCompl) && !rspErr) held++;
      if (flashRead || flashWrite) seen++;
      tick();
    end
    checkOutput("stall_rsp_held", 32'(held), 32'd10);
    checkOutput("stall_no_strobe", 32'(seen), 32'd0);
    rspReady = 1'b1;
    tick();
    checkOutput("stall_idle_gap", {30'd0, flashRead, flashWrite}, 32'd0);
    tick();
    checkOutput("stall_resume_strobe", {31'd0, flashRead}, 32'd1);
    waitIdle("stall_idle");

`ifdef FLASH_TIMEOUT_EN
    begin
      int pulses;
      int lenNow;
      int badLen;
      bit prev;
      $display("[TB] timeout and retries");
      stall    = 1'b1;
      rspReady = 1'b0;
      modelExpectErr = 1'b1;
      applyStimulus(1'b0, 32'h0);
      modelExpectErr = 1'b0;
      pulses = 0;
      lenNow = 0;
      badLen = 0;
      prev   = 1'b0;
      for (int i = 0; i < 200 && !rspValid; i++) begin
        if (flashRead && !prev) begin
          pulses++;
          lenNow = 0;
        end
        if (flashRead) lenNow++;
        if (!flashRead && prev && lenNow != TMO) badLen++;
        prev = flashRead;
        tick();
      end
      checkOutput("tmo_pulses", 32'(pulses), 32'd3);
      checkOutput("tmo_bad_pulse_len", 32'(badLen), 32'd0);
      checkOutput("tmo_rsp_err", {31'd0, rspErr}, 32'd1);
      checkOutput("tmo_rsp_rdata", rspRdata, 32'd0);
      rspReady = 1'b1;
      stall = 1'b0;
      waitIdle("tmo_idle");
    end
`endif

    $display("[TB] randomized traffic");
    startCount = rspCount;
    cyc = 0;
    accepted = 0;
    reqValid = 1'b0;
    while (accepted < 60 && cyc < 5000) begin
      if (!reqValid && ($urandom % 3) != 0) begin
        reqValid = 1'b1;
        reqWrite = 1'($urandom % 2);
        reqWdata = $urandom;
      end
      rspReady = ($urandom % 4) != 0;
      respLat  = int'($urandom % 4);
      acc = reqValid && reqReady;
      tick();
      cyc++;
      if (acc) begin
        accepted++;
        reqValid = 1'b0;
      end
    end
    reqValid = 1'b0;
    rspReady = 1'b1;
    waitIdle("rand_idle");
    checkOutput("rand_rsp_count", 32'(rspCount - startCount), 32'd60);

    $display("[TB] reset mid-WAIT");
    stall    = 1'b1;
    rspReady = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'(i % 2), 32'hC000_0000 + 32'(i));
    tick();
    checkOutput("pre_reset_strobe", {31'd0, flashRead | flashWrite}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_strobes_drop", {30'd0, flashRead, flashWrite}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rspValid}, 32'd0);
    checkOutput("rst_req_ready", {31'd0, reqReady}, 32'd1);
    pendQ.delete();
    modelCompl = 0;
    stall = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rspValid) seen++;
      if (flashRead || flashWrite) strobes++;
    end
    checkOutput("post_reset_no_rsp", 32'(seen), 32'd0);
    checkOutput("post_reset_no_strobe", 32'(strobes), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
